wb_port_arbiter: RTL and testbench

- Shares one scoreboard writeback port between NrReq variable-latency result producers, such as the custom extension FU, CVXIF result path and multiplier.
- Each producer pushes results into a private small FIFO.
- A round-robin scheduler drains one FIFO entry per cycle into a registered writeback slot.
- The slot drives one {trans_id, wbdata, ex, wt_valid} lane of the issue stage.

---
 rtl/wb_port_arbiter_if.sv | 33 +++
 rtl/wb_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the per-requester push lanes and the shared writeback slot of wb_port_arbiter.
// Signal names keep the arbiter-side _i/_o direction suffixes.
interface wb_port_arbiter_if #(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned TransIdBits = 3,
    parameter int unsigned Xlen        = 64,
    parameter int unsigned CauseBits   = 6
) ();
    logic [NrReq-1:0]             req_valid_i;
    logic [NrReq-1:0]             req_ready_o;
    logic [NrReq*TransIdBits-1:0] req_trans_id_i;
    logic [NrReq*Xlen-1:0]        req_data_i;
    logic [NrReq-1:0]             req_ex_valid_i;
    logic [NrReq*CauseBits-1:0]   req_ex_cause_i;
    logic                         wb_valid_o;
    logic [TransIdBits-1:0]       wb_trans_id_o;
    logic [Xlen-1:0]              wb_data_o;
    logic                         wb_ex_valid_o;
    logic [CauseBits-1:0]         wb_ex_cause_o;
    logic [NrReq-1:0]             grant_o;

    modport slave (
        input  req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i, req_ex_cause_i,
        output req_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_valid_o,
               wb_ex_cause_o, grant_o
    );

    modport master (
        output req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i, req_ex_cause_i,
        input  req_ready_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_valid_o,
               wb_ex_cause_o, grant_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one scoreboard writeback port among NrReq producers: per-requester FIFOs
// drained round-robin, one entry per cycle, into a registered writeback slot.
module wb_port_arbiter #(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned TransIdBits = 3,
    parameter int unsigned Xlen        = 64,
    parameter int unsigned CauseBits   = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    wb_port_arbiter_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned IdxW = $clog2(NrReq);

    typedef struct packed {
        logic [TransIdBits-1:0] id;
        logic [Xlen-1:0]        data;
        logic                   ex_valid;
        logic [CauseBits-1:0]   cause;
    } entry_t;

    entry_t          mem_q    [NrReq][FifoDepth];
    logic [PtrW-1:0] wr_ptr_q [NrReq];
    logic [PtrW-1:0] wr_ptr_d [NrReq];
    logic [PtrW-1:0] rd_ptr_q [NrReq];
    logic [PtrW-1:0] rd_ptr_d [NrReq];
    logic [CntW-1:0] cnt_q    [NrReq];
    logic [CntW-1:0] cnt_d    [NrReq];

    logic [NrReq-1:0] ready;
    logic [NrReq-1:0] push;
    logic [NrReq-1:0] grant;
    logic [IdxW-1:0]  rr_q, rr_d;
    logic [IdxW-1:0]  winner;
    logic [IdxW-1:0]  idx;
    logic             found;
    entry_t           slot_q, slot_d;
    logic             wb_valid_q, wb_valid_d;

    // Ready depends on the registered count only, so a same-cycle pop never raises it.
    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            ready[i] = (cnt_q[i] != CntW'(FifoDepth));
        end
    end

    // Round-robin scan starting at rr_q, wrapping modulo NrReq.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        grant  = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            idx = IdxW'((32'(rr_q) + k) % NrReq);
            if (!found && (cnt_q[idx] != '0)) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found && !flush_i) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            push[i]     = bus.req_valid_i[i] & ready[i] & ~flush_i;
            wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(grant[i]);
            cnt_d[i]    = cnt_q[i] + CntW'(push[i]) - CntW'(grant[i]);
            if (flush_i) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
        end
    end

    // No grant keeps id/data/cause but drops both valid flags.
    always_comb begin
        slot_d          = slot_q;
        slot_d.ex_valid = 1'b0;
        wb_valid_d      = 1'b0;
        rr_d            = rr_q;
        if (|grant) begin
            slot_d     = mem_q[winner][rd_ptr_q[winner]];
            wb_valid_d = 1'b1;
            rr_d       = (winner == IdxW'(NrReq - 1)) ? '0 : winner + 1'b1;
        end
        if (flush_i) begin
            rr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= '{
                    id:       bus.req_trans_id_i[i*TransIdBits +: TransIdBits],
                    data:     bus.req_data_i[i*Xlen +: Xlen],
                    ex_valid: bus.req_ex_valid_i[i],
                    cause:    bus.req_ex_cause_i[i*CauseBits +: CauseBits]
                };
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrReq; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_q       <= '0;
            slot_q     <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NrReq; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_q       <= rr_d;
            slot_q     <= slot_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign bus.req_ready_o   = ready;
    assign bus.grant_o       = grant;
    assign bus.wb_valid_o    = wb_valid_q;
    assign bus.wb_trans_id_o = slot_q.id;
    assign bus.wb_data_o     = slot_q.data;
    assign bus.wb_ex_valid_o = slot_q.ex_valid;
    assign bus.wb_ex_cause_o = slot_q.cause;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic compared against
// a queue-based model of the per-requester FIFOs, round-robin pointer and writeback slot.
module tb_wb_port_arbiter;
    localparam int NR    = 3;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    wb_port_arbiter_if #(.NrReq(3), .TransIdBits(3), .Xlen(64), .CauseBits(6)) bus ();

    wb_port_arbiter #(
        .NrReq(3), .FifoDepth(2), .TransIdBits(3), .Xlen(64), .CauseBits(6)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] data;
        logic        exv;
        logic [5:0]  cause;
    } ent_t;

    ent_t q [NR][$];
    ent_t p [NR];
    int   rr;
    ent_t slot;
    logic slot_v;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) q[i].delete();
        rr     = 0;
        slot   = '{id: '0, data: '0, exv: 1'b0, cause: '0};
        slot_v = 1'b0;
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < NR; i++) begin
            p[i].id    = 3'($urandom);
            p[i].data  = {$urandom, $urandom};
            p[i].exv   = ($urandom_range(0, 3) == 0);
            p[i].cause = 6'($urandom);
        end
    endtask

    // Called at a falling edge: drive, check against the model, advance the model, wait a cycle.
    task automatic step(input logic [2:0] v, input logic fl);
        logic [2:0] mrdy;
        logic [2:0] exp_g;
        int         w;
        for (int i = 0; i < NR; i++) begin
            mrdy[i]                      = (q[i].size() < DEPTH);
            bus.req_trans_id_i[i*3 +: 3] = p[i].id;
            bus.req_data_i[i*64 +: 64]   = p[i].data;
            bus.req_ex_valid_i[i]        = p[i].exv;
            bus.req_ex_cause_i[i*6 +: 6] = p[i].cause;
        end
        bus.req_valid_i = v & mrdy;
        flush           = fl;
        #1;
        w = -1;
        if (!fl) begin
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && q[(rr + k) % NR].size() > 0) w = (rr + k) % NR;
            end
        end
        exp_g = (w >= 0) ? 3'(1 << w) : 3'b000;
        check("ready",    bus.req_ready_o, mrdy);
        check("grant",    bus.grant_o, exp_g);
        check("protocol", bus.req_valid_i & ~bus.req_ready_o, 0);
        check("wb_valid", bus.wb_valid_o, slot_v);
        check("wb_id",    bus.wb_trans_id_o, slot.id);
        check("wb_data",  bus.wb_data_o, slot.data);
        check("wb_exv",   bus.wb_ex_valid_o, slot.exv);
        check("wb_cause", bus.wb_ex_cause_o, slot.cause);
        if (fl) begin
            for (int i = 0; i < NR; i++) q[i].delete();
            rr       = 0;
            slot_v   = 1'b0;
            slot.exv = 1'b0;
        end else begin
            if (w >= 0) begin
                slot   = q[w].pop_front();
                slot_v = 1'b1;
                rr     = (w + 1) % NR;
            end else begin
                slot_v   = 1'b0;
                slot.exv = 1'b0;
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid_i[i]) q[i].push_back(p[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid_i    = '0;
        bus.req_trans_id_i = '0;
        bus.req_data_i     = '0;
        bus.req_ex_valid_i = '0;
        bus.req_ex_cause_i = '0;
        model_reset();
        randomize_payload();
        repeat (2) @(negedge clk);

        check("rst_valid", bus.wb_valid_o, 0);
        check("rst_ready", bus.req_ready_o, 3'b111);
        check("rst_grant", bus.grant_o, 0);
        check("rst_id",    bus.wb_trans_id_o, 0);
        check("rst_data",  bus.wb_data_o, 0);
        check("rst_exv",   bus.wb_ex_valid_o, 0);
        check("rst_cause", bus.wb_ex_cause_o, 0);
        rst_n = 1'b1;

        // Single requester, two-cycle latency, one-cycle slot.
        p[1] = '{id: 3'd5, data: 64'hDEAD, exv: 1'b0, cause: 6'd0};
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        check("tp1_valid", bus.wb_valid_o, 1);
        check("tp1_id",    bus.wb_trans_id_o, 5);
        check("tp1_data",  bus.wb_data_o, 64'hDEAD);
        step(3'b000, 1'b0);
        check("tp1_drop",  bus.wb_valid_o, 0);

        // Three simultaneous pushes served in pointer order from 0.
        step(3'b000, 1'b1);
        for (int i = 0; i < NR; i++) p[i] = '{id: 3'(i + 1), data: 64'(100 + i), exv: 1'b0, cause: 6'd0};
        step(3'b111, 1'b0);
        check("tp2_g0", bus.grant_o, 3'b001);
        step(3'b000, 1'b0);
        check("tp2_id0", bus.wb_trans_id_o, 1);
        check("tp2_g1",  bus.grant_o, 3'b010);
        step(3'b000, 1'b0);
        check("tp2_id1", bus.wb_trans_id_o, 2);
        check("tp2_g2",  bus.grant_o, 3'b100);
        step(3'b000, 1'b0);
        check("tp2_id2", bus.wb_trans_id_o, 3);

        // Fairness with req0/req2 streaming and a single req1 push.
        for (int k = 0; k < 12; k++) begin
            randomize_payload();
            step((k == 3) ? 3'b111 : 3'b101, 1'b0);
        end

        // Fill req0 while all three compete.
        for (int k = 0; k < 8; k++) begin
            randomize_payload();
            step(3'b111, 1'b0);
        end

        // Exception passthrough.
        step(3'b000, 1'b1);
        p[2] = '{id: 3'd4, data: 64'h1234, exv: 1'b1, cause: 6'h0D};
        step(3'b100, 1'b0);
        step(3'b000, 1'b0);
        check("tp5_exv",   bus.wb_ex_valid_o, 1);
        check("tp5_cause", bus.wb_ex_cause_o, 6'h0D);
        check("tp5_id",    bus.wb_trans_id_o, 4);

        // Flush with several entries buffered.
        randomize_payload();
        step(3'b111, 1'b0);
        randomize_payload();
        step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        check("tp6_valid", bus.wb_valid_o, 0);
        check("tp6_ready", bus.req_ready_o, 3'b111);
        step(3'b000, 1'b0);
        check("tp6_hold", bus.wb_valid_o, 0);
        p[0] = '{id: 3'd6, data: 64'hBEEF, exv: 1'b0, cause: 6'd0};
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        check("tp6_new_v",  bus.wb_valid_o, 1);
        check("tp6_new_id", bus.wb_trans_id_o, 6);

        // Random traffic with occasional flushes.
        for (int k = 0; k < 1500; k++) begin
            randomize_payload();
            step(3'($urandom), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset in the middle of traffic.
        randomize_payload();
        bus.req_valid_i = 3'b111 & bus.req_ready_o;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.wb_valid_o, 0);
        check("arst_ready", bus.req_ready_o, 3'b111);
        check("arst_grant", bus.grant_o, 0);
        check("arst_data",  bus.wb_data_o, 0);
        check("arst_exv",   bus.wb_ex_valid_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            randomize_payload();
            step(3'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
